// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station: opcode encoding, datapath widths and the "no producer" tag.
// Build option RS_OLDEST_FIRST_EN (see reservation_station.sv) selects age-based issue.
package reservation_station_pkg;

  localparam int OPE_WIDTH       = 6;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int ROB_SIZE_ARR    = 32;
  localparam int NON_DEPENDENT   = 0;
  localparam int RS_SIZE_DEFAULT = 16;

  localparam logic [OPE_WIDTH-1:0] OP_NOP = 6'd0;
  localparam logic [OPE_WIDTH-1:0] OP_ADD = 6'd1;
  localparam logic [OPE_WIDTH-1:0] OP_SUB = 6'd2;
  localparam logic [OPE_WIDTH-1:0] OP_AND = 6'd3;
  localparam logic [OPE_WIDTH-1:0] OP_OR  = 6'd4;
  localparam logic [OPE_WIDTH-1:0] OP_XOR = 6'd5;
  localparam logic [OPE_WIDTH-1:0] OP_BEQ = 6'd16;
  localparam logic [OPE_WIDTH-1:0] OP_BNE = 6'd17;

endpackage

// File: rtl/reservation_station_select.sv
// Issue selector: picks one ready entry. Lowest index wins by default; with RS_OLDEST_FIRST_EN
// the entry with the largest age wins, ties going to the lowest index.
module reservation_station_select
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  localparam int IDX_W  = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0]            ready,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [RS_SIZE-1:0][IDX_W-1:0] age,
`endif
  output logic [IDX_W-1:0]              idx,
  output logic                          found
);

`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] best_age;

  always_comb begin
    idx      = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!found || age[i] > best_age)) begin
        idx      = IDX_W'(i);
        found    = 1'b1;
        best_age = age[i];
      end
    end
  end
`else
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reservation_station.sv
// Reservation station for ALU/branch ops: captures renamed operands, snoops both CDBs, issues one
// ready op per cycle. Define RS_OLDEST_FIRST_EN for oldest-first issue instead of lowest-index.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE      = RS_SIZE_DEFAULT,
  parameter int ROB_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    mispredict,
  input  logic                    enable_from_dispatcher,
  input  logic [OPE_WIDTH-1:0]    type_from_dispatcher,
  input  logic [4:0]              rd_from_dispatcher,
  input  logic [DATA_WIDTH-1:0]   imm_from_dispatcher,
  input  logic [ADDR_WIDTH-1:0]   pc_from_dispatcher,
  input  logic [DATA_WIDTH-1:0]   Vj_from_dispatcher,
  input  logic [DATA_WIDTH-1:0]   Vk_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] Qj_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] Qk_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_from_dispatcher,
  output logic                    full_to_dispatcher,
  input  logic                    enable_cdb_rs,
  input  logic [ROB_ID_WIDTH-1:0] cdb_rs_rob_id,
  input  logic [DATA_WIDTH-1:0]   cdb_rs_value,
  input  logic                    enable_cdb_lsb,
  input  logic [ROB_ID_WIDTH-1:0] cdb_lsb_rob_id,
  input  logic [DATA_WIDTH-1:0]   cdb_lsb_value,
  output logic                    enable_to_alu,
  output logic [OPE_WIDTH-1:0]    type_to_alu,
  output logic [DATA_WIDTH-1:0]   Vj_to_alu,
  output logic [DATA_WIDTH-1:0]   Vk_to_alu,
  output logic [DATA_WIDTH-1:0]   imm_to_alu,
  output logic [ADDR_WIDTH-1:0]   pc_to_alu,
  output logic [ROB_ID_WIDTH-1:0] rob_id_to_alu
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [ROB_ID_WIDTH-1:0] ND = ROB_ID_WIDTH'(NON_DEPENDENT);

  logic [RS_SIZE-1:0]      valid, valid_next, ready;
  logic [OPE_WIDTH-1:0]    op_type [RS_SIZE];
  logic [DATA_WIDTH-1:0]   vj [RS_SIZE];
  logic [DATA_WIDTH-1:0]   vk [RS_SIZE];
  logic [DATA_WIDTH-1:0]   imm [RS_SIZE];
  logic [ADDR_WIDTH-1:0]   pc [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] qj [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] qk [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] rob_id [RS_SIZE];

  logic [IDX_W-1:0]        free_idx, sel_idx;
  logic                    any_free, sel_found, do_write, full_next;
  logic [IDX_W:0]          free_cnt;
  logic [DATA_WIDTH-1:0]   in_vj, in_vk;
  logic [ROB_ID_WIDTH-1:0] in_qj, in_qk;

  // The destination register is tracked by the ROB, not here.
  logic unused_rd;
  assign unused_rd = ^rd_from_dispatcher;

  function automatic logic tag_hit(input logic en, input logic [ROB_ID_WIDTH-1:0] tag,
                                   input logic [ROB_ID_WIDTH-1:0] q);
    return en && (q != ND) && (tag == q);
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      ready[i] = valid[i] && (qj[i] == ND) && (qk[i] == ND);
  end

  // Free slots come from pre-edge valid bits; a slot freed by issue is reused from the next cycle.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign do_write = enable_from_dispatcher && any_free;

`ifdef RS_OLDEST_FIRST_EN
  logic [RS_SIZE-1:0][IDX_W-1:0] age;

  reservation_station_select #(.RS_SIZE(RS_SIZE)) u_select (
    .ready (ready),
    .age   (age),
    .idx   (sel_idx),
    .found (sel_found)
  );
`else
  reservation_station_select #(.RS_SIZE(RS_SIZE)) u_select (
    .ready (ready),
    .idx   (sel_idx),
    .found (sel_found)
  );
`endif

  always_comb begin
    in_vj = Vj_from_dispatcher;
    in_qj = Qj_from_dispatcher;
    in_vk = Vk_from_dispatcher;
    in_qk = Qk_from_dispatcher;
    if (tag_hit(enable_cdb_rs, cdb_rs_rob_id, Qj_from_dispatcher)) begin
      in_vj = cdb_rs_value;
      in_qj = ND;
    end else if (tag_hit(enable_cdb_lsb, cdb_lsb_rob_id, Qj_from_dispatcher)) begin
      in_vj = cdb_lsb_value;
      in_qj = ND;
    end
    if (tag_hit(enable_cdb_rs, cdb_rs_rob_id, Qk_from_dispatcher)) begin
      in_vk = cdb_rs_value;
      in_qk = ND;
    end else if (tag_hit(enable_cdb_lsb, cdb_lsb_rob_id, Qk_from_dispatcher)) begin
      in_vk = cdb_lsb_value;
      in_qk = ND;
    end
  end

  always_comb begin
    valid_next = valid;
    if (sel_found) valid_next[sel_idx] = 1'b0;
    if (do_write)  valid_next[free_idx] = 1'b1;
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++)
      free_cnt = free_cnt + {{IDX_W{1'b0}}, ~valid_next[i]};
    full_next = (free_cnt <= (IDX_W+1)'(1));
  end

  // Entry payload and wakeup: no reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (do_write && free_idx == IDX_W'(i)) begin
          op_type[i] <= type_from_dispatcher;
          imm[i]     <= imm_from_dispatcher;
          pc[i]      <= pc_from_dispatcher;
          rob_id[i]  <= rob_id_from_dispatcher;
          vj[i]      <= in_vj;
          qj[i]      <= in_qj;
          vk[i]      <= in_vk;
          qk[i]      <= in_qk;
        end else begin
          if (tag_hit(enable_cdb_rs, cdb_rs_rob_id, qj[i])) begin
            vj[i] <= cdb_rs_value;
            qj[i] <= ND;
          end else if (tag_hit(enable_cdb_lsb, cdb_lsb_rob_id, qj[i])) begin
            vj[i] <= cdb_lsb_value;
            qj[i] <= ND;
          end
          if (tag_hit(enable_cdb_rs, cdb_rs_rob_id, qk[i])) begin
            vk[i] <= cdb_rs_value;
            qk[i] <= ND;
          end else if (tag_hit(enable_cdb_lsb, cdb_lsb_rob_id, qk[i])) begin
            vk[i] <= cdb_lsb_value;
            qk[i] <= ND;
          end
        end
      end
    end
  end

  // Issue register stage: control and ALU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst || (rdy && mispredict)) begin
      valid              <= '0;
      full_to_dispatcher <= 1'b0;
      enable_to_alu      <= 1'b0;
      type_to_alu        <= '0;
      Vj_to_alu          <= '0;
      Vk_to_alu          <= '0;
      imm_to_alu         <= '0;
      pc_to_alu          <= '0;
      rob_id_to_alu      <= '0;
    end else if (rdy) begin
      valid              <= valid_next;
      full_to_dispatcher <= full_next;
      enable_to_alu      <= sel_found;
      if (sel_found) begin
        type_to_alu   <= op_type[sel_idx];
        Vj_to_alu     <= vj[sel_idx];
        Vk_to_alu     <= vk[sel_idx];
        imm_to_alu    <= imm[sel_idx];
        pc_to_alu     <= pc[sel_idx];
        rob_id_to_alu <= rob_id[sel_idx];
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Ages count dispatches since write and saturate, so ties resolve to the lowest index.
  always_ff @(posedge clk) begin
    if (rst || (rdy && mispredict)) begin
      age <= '0;
    end else if (rdy && do_write) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (free_idx == IDX_W'(i))
          age[i] <= '0;
        else if (valid[i] && age[i] != '1)
          age[i] <= age[i] + 1'b1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && rdy && !mispredict && enable_from_dispatcher && !any_free)
      $error("reservation_station: dispatch while full, op dropped");
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; expected order of the age test follows RS_OLDEST_FIRST_EN.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst, rdy, mispredict, enable_from_dispatcher;
  logic [OPE_WIDTH-1:0]  type_from_dispatcher;
  logic [4:0]            rd_from_dispatcher;
  logic [31:0]           imm_from_dispatcher, pc_from_dispatcher;
  logic [31:0]           Vj_from_dispatcher, Vk_from_dispatcher;
  logic [4:0]            Qj_from_dispatcher, Qk_from_dispatcher, rob_id_from_dispatcher;
  logic                  full_to_dispatcher;
  logic                  enable_cdb_rs, enable_cdb_lsb;
  logic [4:0]            cdb_rs_rob_id, cdb_lsb_rob_id;
  logic [31:0]           cdb_rs_value, cdb_lsb_value;
  logic                  enable_to_alu;
  logic [OPE_WIDTH-1:0]  type_to_alu;
  logic [31:0]           Vj_to_alu, Vk_to_alu, imm_to_alu, pc_to_alu;
  logic [4:0]            rob_id_to_alu;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict),
    .enable_from_dispatcher(enable_from_dispatcher),
    .type_from_dispatcher(type_from_dispatcher), .rd_from_dispatcher(rd_from_dispatcher),
    .imm_from_dispatcher(imm_from_dispatcher), .pc_from_dispatcher(pc_from_dispatcher),
    .Vj_from_dispatcher(Vj_from_dispatcher), .Vk_from_dispatcher(Vk_from_dispatcher),
    .Qj_from_dispatcher(Qj_from_dispatcher), .Qk_from_dispatcher(Qk_from_dispatcher),
    .rob_id_from_dispatcher(rob_id_from_dispatcher), .full_to_dispatcher(full_to_dispatcher),
    .enable_cdb_rs(enable_cdb_rs), .cdb_rs_rob_id(cdb_rs_rob_id), .cdb_rs_value(cdb_rs_value),
    .enable_cdb_lsb(enable_cdb_lsb), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .enable_to_alu(enable_to_alu), .type_to_alu(type_to_alu), .Vj_to_alu(Vj_to_alu),
    .Vk_to_alu(Vk_to_alu), .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
    .rob_id_to_alu(rob_id_to_alu)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] qj, input logic [4:0] qk, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [4:0] rob);
    enable_from_dispatcher = 1'b1;
    type_from_dispatcher   = OP_ADD;
    Qj_from_dispatcher     = qj;
    Qk_from_dispatcher     = qk;
    Vj_from_dispatcher     = vj;
    Vk_from_dispatcher     = vk;
    rob_id_from_dispatcher = rob;
    imm_from_dispatcher    = 32'h100 + 32'(rob);
    pc_from_dispatcher     = 32'h4000 + 32'(rob);
  endtask

  task automatic cdb(input logic rs_en, input logic [4:0] rs_tag, input logic [31:0] rs_val,
                     input logic lsb_en, input logic [4:0] lsb_tag, input logic [31:0] lsb_val);
    enable_cdb_rs  = rs_en;
    cdb_rs_rob_id  = rs_tag;
    cdb_rs_value   = rs_val;
    enable_cdb_lsb = lsb_en;
    cdb_lsb_rob_id = lsb_tag;
    cdb_lsb_value  = lsb_val;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; mispredict = 1'b0;
    enable_from_dispatcher = 1'b0; type_from_dispatcher = OP_NOP; rd_from_dispatcher = 5'd1;
    imm_from_dispatcher = '0; pc_from_dispatcher = '0;
    Vj_from_dispatcher = '0; Vk_from_dispatcher = '0;
    Qj_from_dispatcher = '0; Qk_from_dispatcher = '0; rob_id_from_dispatcher = '0;
    cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    check_val("reset_en", 32'(enable_to_alu), 32'd0);
    check_val("reset_full", 32'(full_to_dispatcher), 32'd0);
    check_val("reset_vj", Vj_to_alu, 32'd0);
    check_val("reset_rob", 32'(rob_id_to_alu), 32'd0);

    // simple ready ADD
    disp(5'd0, 5'd0, 32'd5, 32'd7, 5'd3);
    tick(); enable_from_dispatcher = 1'b0;
    check_val("t1_latency", 32'(enable_to_alu), 32'd0);
    tick();
    check_val("t1_en", 32'(enable_to_alu), 32'd1);
    check_val("t1_vj", Vj_to_alu, 32'd5);
    check_val("t1_vk", Vk_to_alu, 32'd7);
    check_val("t1_rob", 32'(rob_id_to_alu), 32'd3);
    check_val("t1_type", 32'(type_to_alu), 32'(OP_ADD));
    check_val("t1_imm", imm_to_alu, 32'h103);
    check_val("t1_pc", pc_to_alu, 32'h4003);
    tick();
    check_val("t1_pulse", 32'(enable_to_alu), 32'd0);

    // wakeup from cdb_rs, then capture from cdb_lsb at dispatch
    disp(5'd4, 5'd0, 32'd0, 32'd1, 5'd5);
    tick(); enable_from_dispatcher = 1'b0;
    cdb(1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 32'd0);
    tick(); cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("t2a_wait", 32'(enable_to_alu), 32'd0);
    tick();
    check_val("t2a_en", 32'(enable_to_alu), 32'd1);
    check_val("t2a_vj", Vj_to_alu, 32'h10);
    check_val("t2a_rob", 32'(rob_id_to_alu), 32'd5);
    disp(5'd4, 5'd0, 32'd0, 32'd2, 5'd6);
    cdb(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h20);
    tick(); enable_from_dispatcher = 1'b0; cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("t2b_wait", 32'(enable_to_alu), 32'd0);
    tick();
    check_val("t2b_en", 32'(enable_to_alu), 32'd1);
    check_val("t2b_vj", Vj_to_alu, 32'h20);
    check_val("t2b_vk", Vk_to_alu, 32'd2);
    check_val("t2b_rob", 32'(rob_id_to_alu), 32'd6);
    tick();

    // fill all 16 entries waiting on tag 9
    for (int i = 0; i < 16; i++) begin
      disp(5'd9, 5'd0, 32'd0, 32'(i), 5'(i + 10));
      tick(); enable_from_dispatcher = 1'b0;
      if (i == 13) check_val("t3_full_14", 32'(full_to_dispatcher), 32'd0);
      if (i == 14) check_val("t3_full_15", 32'(full_to_dispatcher), 32'd1);
    end
    check_val("t3_full_16", 32'(full_to_dispatcher), 32'd1);
    check_val("t3_noissue", 32'(enable_to_alu), 32'd0);
    cdb(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    tick(); cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("t3_wake", 32'(enable_to_alu), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val("t3_en", 32'(enable_to_alu), 32'd1);
      check_val("t3_rob", 32'(rob_id_to_alu), 32'(i + 10));
      check_val("t3_vk", Vk_to_alu, 32'(i));
      if (i == 0) check_val("t3_full_free1", 32'(full_to_dispatcher), 32'd1);
      if (i == 1) check_val("t3_full_free2", 32'(full_to_dispatcher), 32'd0);
    end
    tick();
    check_val("t3_drained", 32'(enable_to_alu), 32'd0);

    // mispredict beats a simultaneous wakeup
    for (int i = 0; i < 6; i++) begin
      disp((i == 5) ? 5'd7 : 5'd6, 5'd0, 32'd0, 32'd0, 5'(i + 1));
      tick(); enable_from_dispatcher = 1'b0;
    end
    mispredict = 1'b1;
    cdb(1'b1, 5'd6, 32'd1, 1'b0, 5'd0, 32'd0);
    tick(); mispredict = 1'b0; cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("t4_en", 32'(enable_to_alu), 32'd0);
    check_val("t4_full", 32'(full_to_dispatcher), 32'd0);
    check_val("t4_vj_clr", Vj_to_alu, 32'd0);
    tick();
    check_val("t4_noissue", 32'(enable_to_alu), 32'd0);
    cdb(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0);
    tick(); cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check_val("t4_gone", 32'(enable_to_alu), 32'd0);

    // rdy=0 freezes issue and wakeup
    disp(5'd13, 5'd0, 32'd0, 32'd0, 5'd11);
    tick();
    disp(5'd0, 5'd0, 32'h77, 32'd0, 5'd12);
    tick(); enable_from_dispatcher = 1'b0;
    rdy = 1'b0;
    cdb(1'b1, 5'd13, 32'h55, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_hold", 32'(enable_to_alu), 32'd0);
    end
    rdy = 1'b1; cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check_val("t5_resume_en", 32'(enable_to_alu), 32'd1);
    check_val("t5_resume_rob", 32'(rob_id_to_alu), 32'd12);
    check_val("t5_resume_vj", Vj_to_alu, 32'h77);
    tick();
    check_val("t5_no_wake", 32'(enable_to_alu), 32'd0);
    cdb(1'b1, 5'd13, 32'h66, 1'b0, 5'd0, 32'd0);
    tick(); cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check_val("t5_late_en", 32'(enable_to_alu), 32'd1);
    check_val("t5_late_rob", 32'(rob_id_to_alu), 32'd11);
    check_val("t5_late_vj", Vj_to_alu, 32'h66);

    // issue order: idx 7 written before idx 1
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp((i == 1) ? 5'd21 : ((i == 7) ? 5'd22 : 5'd20), 5'd0, 32'd0, 32'd0, 5'(i + 1));
      tick(); enable_from_dispatcher = 1'b0;
    end
    cdb(1'b1, 5'd21, 32'd0, 1'b0, 5'd0, 32'd0);
    tick(); cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check_val("t6_free_idx1", 32'(rob_id_to_alu), 32'd2);
    disp(5'd23, 5'd0, 32'd0, 32'd0, 5'd30);
    tick(); enable_from_dispatcher = 1'b0;
    cdb(1'b1, 5'd22, 32'hA, 1'b1, 5'd23, 32'hB);
    tick(); cdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("t6_wake", 32'(enable_to_alu), 32'd0);
    tick();
    check_val("t6_first_en", 32'(enable_to_alu), 32'd1);
`ifdef RS_OLDEST_FIRST_EN
    check_val("t6_first", 32'(rob_id_to_alu), 32'd8);
`else
    check_val("t6_first", 32'(rob_id_to_alu), 32'd30);
`endif
    tick();
    check_val("t6_second_en", 32'(enable_to_alu), 32'd1);
`ifdef RS_OLDEST_FIRST_EN
    check_val("t6_second", 32'(rob_id_to_alu), 32'd30);
`else
    check_val("t6_second", 32'(rob_id_to_alu), 32'd8);
`endif
    tick();
    check_val("t6_idle", 32'(enable_to_alu), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
